ram16x8_arbiter: RTL and testbench



---
 rtl/ram16x8_arbiter.sv | 134 +++++++++++++
 tb/tb_ram16x8_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram16x8_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for the 16x8 RAM.
// Define RAM_ARB_FIXED_PRIO_EN to make port A win every tie.
module ram16x8_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_ce,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD1,
    RD2
  } state_t;

  state_t              r_state;
  logic                r_last_b;
  logic                r_win_b;
  logic                w_any;
  logic                w_win_b;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_any   = req_a | req_b;
  assign w_we    = w_win_b ? we_b : we_a;
  assign w_addr  = w_win_b ? addr_b : addr_a;
  assign w_wdata = w_win_b ? wdata_b : wdata_a;
  assign busy    = (r_state != IDLE);

  // Tie goes to the port that was not granted last.
  always_comb begin
    w_win_b = 1'b0;
    unique case (1'b1)
      (req_a && !req_b): w_win_b = 1'b0;
      (!req_a && req_b): w_win_b = 1'b1;
      default: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        w_win_b = 1'b0;
`else
        w_win_b = ~r_last_b;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_b    <= 1'b1;
      r_win_b     <= 1'b0;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      ram_ce      <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= w_we ? WR : RD1;
            r_win_b     <= w_win_b;
            r_last_b    <= w_win_b;
            gnt_a       <= ~w_win_b;
            gnt_b       <= w_win_b;
            ram_ce      <= 1'b1;
            ram_wr_en   <= w_we;
            ram_rd_en   <= ~w_we;
            ram_addr    <= w_addr;
            ram_data_in <= w_wdata;
          end
        end
        WR: begin
          r_state   <= IDLE;
          ram_ce    <= 1'b0;
          ram_wr_en <= 1'b0;
        end
        RD1: begin
          r_state <= RD2;
        end
        RD2: begin
          r_state   <= IDLE;
          ram_ce    <= 1'b0;
          ram_rd_en <= 1'b0;
          if (ram_valid) begin
            if (r_win_b) begin
              rdata_b  <= ram_data_out;
              rvalid_b <= 1'b1;
            end else begin
              rdata_a  <= ram_data_out;
              rvalid_a <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram16x8_arbiter.sv
// Bench for ram16x8_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_ram16x8_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, we_a, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       ram_ce, ram_rd_en, ram_wr_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       ram_valid;
  logic       busy;
  logic       inval;

  ram16x8_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b),
    .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_ce(ram_ce), .ram_rd_en(ram_rd_en),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out),
    .ram_valid(ram_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, combinational read.
  logic [7:0] ram_mem [16];
  always @(posedge clk)
    if (ram_ce && ram_wr_en) ram_mem[ram_addr] <= ram_data_in;
  assign ram_data_out = (ram_ce && ram_rd_en) ? ram_mem[ram_addr] : 8'h00;
  assign ram_valid = ram_ce & ram_rd_en & ~inval;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, a write lasts one cycle,
  // a read two, and each is followed by at least one idle cycle.
  logic [7:0] mdl_mem [16];
  bit         m_act, m_we, m_win, m_last;
  int         m_age;
  logic [3:0] m_addr;
  logic [7:0] m_din;
  bit         e_gnt_a, e_gnt_b, e_rv_a, e_rv_b;
  logic [7:0] e_rd_a, e_rd_b;
  bit         auto_drop;

  task automatic model_reset();
    m_act = 0; m_we = 0; m_win = 0; m_last = 1; m_age = 0;
    m_addr = 0; m_din = 0;
    e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0;
    e_rd_a = 0; e_rd_b = 0;
  endtask

  task automatic model_step();
    bit w;
    e_gnt_a = 0; e_gnt_b = 0; e_rv_a = 0; e_rv_b = 0;
    if (m_act) begin
      if (m_we) begin
        mdl_mem[m_addr] = m_din;
        m_act = 0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else begin
        m_act = 0;
        if (!inval) begin
          if (m_win) begin e_rv_b = 1; e_rd_b = mdl_mem[m_addr]; end
          else begin e_rv_a = 1; e_rd_a = mdl_mem[m_addr]; end
        end
      end
    end else if (req_a || req_b) begin
      if (req_a && !req_b) w = 0;
      else if (!req_a) w = 1;
      else begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = !m_last;
`endif
      end
      m_last = w; m_win = w; m_act = 1; m_age = 0;
      m_we   = w ? we_b : we_a;
      m_addr = w ? addr_b : addr_a;
      m_din  = w ? wdata_b : wdata_a;
      if (w) e_gnt_b = 1; else e_gnt_a = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    chk("gnt_a", gnt_a, e_gnt_a);
    chk("gnt_b", gnt_b, e_gnt_b);
    chk("gnt_excl", gnt_a & gnt_b, 0);
    chk("rvalid_a", rvalid_a, e_rv_a);
    chk("rvalid_b", rvalid_b, e_rv_b);
    chk("rdata_a", rdata_a, e_rd_a);
    chk("rdata_b", rdata_b, e_rd_b);
    chk("ram_ce", ram_ce, m_act);
    chk("ram_wr_en", ram_wr_en, m_act && m_we);
    chk("ram_rd_en", ram_rd_en, m_act && !m_we);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_data_in", ram_data_in, m_din);
    chk("busy", busy, m_act);
    if (auto_drop && e_gnt_a) req_a = 0;
    if (auto_drop && e_gnt_b) req_b = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) cycle();
    rst_n = 1;
  endtask

  int obs [$];
  int lat;
  bit seen;

  initial begin
    rst_n = 0; inval = 0; auto_drop = 1;
    req_a = 0; req_b = 0; we_a = 0; we_b = 0;
    addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 8'(i * 37 + 5);
      mdl_mem[i] = 8'(i * 37 + 5);
    end
    model_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_gnt", {gnt_a, gnt_b, rvalid_a, rvalid_b}, 0);
    do_reset();

    req_a = 1; we_a = 1; addr_a = 4'd3; wdata_a = 8'h5A;
    cycle();
    chk("w5a_gnt", gnt_a, 1);
    chk("w5a_addr", ram_addr, 4'd3);
    chk("w5a_din", ram_data_in, 8'h5A);
    repeat (2) cycle();

    req_a = 1; we_a = 1; addr_a = 4'd15; wdata_a = 8'hC3;
    repeat (2) cycle();
    req_a = 1; we_a = 0; addr_a = 4'd15;
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      cycle(); lat++;
      if (rvalid_a) seen = 1;
      chk("rb_rvalid_b", rvalid_b, 0);
    end
    chk("rb_lat", lat, 3);
    chk("rb_data", rdata_a, 8'hC3);
    cycle();

    do_reset();
    auto_drop = 0;
    req_a = 1; we_a = 0; addr_a = 4'd1;
    req_b = 1; we_b = 0; addr_b = 4'd2;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (gnt_a) obs.push_back(0);
      if (gnt_b) obs.push_back(1);
    end
    chk("cont_cnt", obs.size(), 5);
    for (int i = 0; i < obs.size() && i < 5; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("cont_order", obs[i], 0);
`else
      chk("cont_order", obs[i], i % 2);
`endif
    end
    auto_drop = 1;
    req_a = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle();
      if (gnt_b) seen = 1;
    end
    chk("drop_a_gnt_b", seen, 1);
    repeat (3) cycle();

    req_a = 1; we_a = 0; addr_a = 4'd5;
    repeat (2) cycle();
    chk("mid_rd2_ce", ram_ce, 1);
    rst_n = 0;
    #1;
    chk("mid_ce_drop", ram_ce, 0);
    chk("mid_rd_drop", ram_rd_en, 0);
    model_reset();
    req_a = 0;
    cycle();
    chk("mid_no_rvalid", rvalid_a, 0);
    rst_n = 1;

    req_a = 1; we_a = 1; addr_a = 4'd7; wdata_a = 8'h11;
    req_b = 1; we_b = 0; addr_b = 4'd7;
    cycle();
    chk("tie_first_a", gnt_a, 1);
    repeat (7) cycle();
    chk("wr_rd_b", rdata_b, 8'h11);

    for (int i = 0; i < 600; i++) begin
      cycle();
      inval = ($urandom % 8 == 0);
      if (!req_a && $urandom % 3 == 0) begin
        req_a = 1; we_a = $urandom % 2 == 0;
        addr_a = 4'($urandom); wdata_a = 8'($urandom);
      end
      if (!req_b && $urandom % 3 == 0) begin
        req_b = 1; we_b = $urandom % 2 == 0;
        addr_b = 4'($urandom); wdata_b = 8'($urandom);
      end
      if (i % 200 == 150) rst_n = 0;
      else rst_n = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
